// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
//   Consumer-side engine for a FIFO read port. Pops words using the FIFO's
//   RD strobe / empty flag (registered dataOut, one-cycle read latency) and
//   presents them as a valid/ready stream through a 2-entry output buffer,
//   so it sustains one word per cycle while absorbing sink backpressure.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   enable     1 = fetch from FIFO, 0 = stop issuing new pops
//   fifo_rd    pop strobe to the FIFO (combinational)
//   fifo_empty FIFO empty flag
//   fifo_data  FIFO dataOut, valid the cycle after a pop
//   m_valid    stream word valid
//   m_data     stream word
//   m_ready    sink accepts when m_valid && m_ready
//   words_read number of pops issued since reset (wraps)
//   busy       pop in flight or buffer non-empty
// -----------------------------------------------------------------------------
module fifo_reader #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  fifo_rd,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  words_read,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [CNT_WIDTH-1:0]  r_words;
  logic                  w_pop_out;
  logic                  w_push;
  logic [2:0]            w_level;

  assign m_valid    = (r_occ != 2'd0);
  assign m_data     = r_head;
  assign w_pop_out  = m_valid && m_ready;
  // Data popped last cycle is on fifo_data now and lands in the buffer.
  assign w_push     = r_inflight;
  // Entries the buffer will hold once this cycle's push/pop settle. A new pop
  // is only allowed if there is room left for the word it brings back, so the
  // buffer can never overflow. w_pop_out implies r_occ>=1: no underflow.
  assign w_level    = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop_out};
  assign fifo_rd    = !rst && (r_state == RUN) && !fifo_empty && (w_level < 3'd2);
  assign busy       = r_inflight || m_valid;
  assign words_read = r_words;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (enable) w_state_next = RUN;
      RUN:  if (!enable) w_state_next = STOP;
      STOP: begin
        if (enable)           w_state_next = RUN;
        else if (!r_inflight) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_inflight <= 1'b0;
      r_words    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= fifo_rd;
      if (fifo_rd) r_words <= r_words + 1'b1;
    end
  end

  // NOTE: the buffer data registers are reset too, because m_data is defined
  // to read 0 after reset rather than whatever was last stored.
  // Clearing r_inflight on reset also drops a word returning the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= 2'd0;
    end else begin
      unique case ({w_push, w_pop_out})
        2'b10: begin
          if (r_occ == 2'd0) r_head <= fifo_data;
          else               r_tail <= fifo_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          // Head leaves and a new word arrives: occupancy is unchanged and
          // the new word goes behind whatever remains.
          if (r_occ == 2'd2) begin
            r_head <= r_tail;
            r_tail <= fifo_data;
          end else begin
            r_head <= fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
